// File: rtl/fusion_pkg.sv
// -----------------------------------------------------------------------------
// fusion_pkg
// Shared definitions for the fusion accumulator slice:
//   - COL_WIDTH_DEF : default lane width of one upstream fusion-unit partial sum
//   - WW_*          : one-hot weight-precision encodings carried on weight_width
//   - state_e       : accumulator FSM states
//   - run_cfg_t     : per-run configuration captured when a run starts
// -----------------------------------------------------------------------------
package fusion_pkg;

  localparam int COL_WIDTH_DEF = 13;

  // One-hot weight precision. Anything that is not one of these is handled
  // exactly like 2b, which is also how 1b is handled.
  localparam logic [3:0] WW_1B = 4'b0001;
  localparam logic [3:0] WW_2B = 4'b0010;
  localparam logic [3:0] WW_4B = 4'b0100;
  localparam logic [3:0] WW_8B = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Configuration frozen for the whole run so that upstream may change its
  // mode pins while a result is still being built.
  typedef struct packed {
    logic [3:0] ww;
    logic       sgn;
  } run_cfg_t;

endpackage : fusion_pkg

// File: rtl/psum_combine.sv
// -----------------------------------------------------------------------------
// psum_combine
// Purely combinational merge of the four packed lanes coming out of the
// fusion unit into one signed partial sum, according to the weight precision.
//   1b / 2b / non-one-hot : four COL_WIDTH lanes, lane i weighted by 4^i
//   4b                    : two 2*COL_WIDTH lanes, upper lane weighted by 16
//   8b                    : the whole bus is a single value
// Lanes are sign-extended when sgn_i=1, zero-extended otherwise.
//
// Ports
//   weight_width_i  in   4          one-hot precision (see fusion_pkg::WW_*)
//   sgn_i           in   1          treat lanes as two's complement
//   psum_i          in   4*COL_W    packed lanes, lane 0 in the LSBs
//   combined_o      out  OUT_WIDTH  signed merged value
// -----------------------------------------------------------------------------
module psum_combine
  import fusion_pkg::*;
#(
  parameter int COL_WIDTH = COL_WIDTH_DEF,
  // Two spare bits above the 8b value keep an unsigned full-width bus positive
  // and give the shifted 1b/2b and 4b sums room to grow.
  parameter int OUT_WIDTH = 4 * COL_WIDTH + 2
) (
  input  logic [3:0]                  weight_width_i,
  input  logic                        sgn_i,
  input  logic [4*COL_WIDTH-1:0]      psum_i,
  output logic signed [OUT_WIDTH-1:0] combined_o
);

  localparam int HALF_W = 2 * COL_WIDTH;
  localparam int FULL_W = 4 * COL_WIDTH;

  logic signed [OUT_WIDTH-1:0] lane_ext [4];
  logic signed [OUT_WIDTH-1:0] half_ext [2];
  logic signed [OUT_WIDTH-1:0] full_ext;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane_ext[i] = {{(OUT_WIDTH - COL_WIDTH){sgn_i & psum_i[(i+1)*COL_WIDTH-1]}},
                          psum_i[i*COL_WIDTH +: COL_WIDTH]};
  end

  for (genvar i = 0; i < 2; i++) begin : g_half
    assign half_ext[i] = {{(OUT_WIDTH - HALF_W){sgn_i & psum_i[(i+1)*HALF_W-1]}},
                          psum_i[i*HALF_W +: HALF_W]};
  end

  assign full_ext = {{(OUT_WIDTH - FULL_W){sgn_i & psum_i[FULL_W-1]}}, psum_i};

  always_comb begin
    case (weight_width_i)
      WW_8B:   combined_o = full_ext;
      WW_4B:   combined_o = half_ext[0] + (half_ext[1] <<< 4);
      // WW_1B, WW_2B and every non-one-hot code share the four-lane merge.
      default: combined_o = lane_ext[0]
                          + (lane_ext[1] <<< 2)
                          + (lane_ext[2] <<< 4)
                          + (lane_ext[3] <<< 6);
    endcase
  end

endmodule : psum_combine

// File: rtl/fusion_accumulator.sv
// -----------------------------------------------------------------------------
// fusion_accumulator
// Accumulates acc_len merged partial-sum beats from the fusion unit into a
// saturating ACC_WIDTH result, then holds it until downstream accepts it.
// IDLE -> (start, acc_len!=0) -> ACCUM -> (count==acc_len) -> HOLD
//      -> (acc_ready) -> IDLE
//
// Ports
//   clk          in   1            rising-edge clock
//   rst          in   1            asynchronous active-high reset
//   start        in   1            begin a run (ignored unless IDLE)
//   acc_len      in   LEN_WIDTH    beats in the run (0 = ignore start)
//   weight_width in   4            one-hot weight precision
//   s_in         in   1            input operand signed
//   s_weight     in   1            weight operand signed
//   psum_in      in   4*COL_WIDTH  packed lanes from the fusion unit
//   psum_valid   in   1            psum_in carries a beat this cycle
//   busy         out  1            run in progress or result held
//   acc_out      out  ACC_WIDTH    accumulated (saturated) result
//   acc_valid    out  1            acc_out is the finished result
//   acc_ready    in   1            downstream takes acc_out
//   sat          out  1            sticky: this run saturated at least once
// -----------------------------------------------------------------------------
module fusion_accumulator
  import fusion_pkg::*;
#(
  parameter int COL_WIDTH = COL_WIDTH_DEF,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   acc_len,
  input  logic [3:0]             weight_width,
  input  logic                   s_in,
  input  logic                   s_weight,
  input  logic [4*COL_WIDTH-1:0] psum_in,
  input  logic                   psum_valid,
  output logic                   busy,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   acc_valid,
  input  logic                   acc_ready,
  output logic                   sat
);

  localparam int COMB_W = 4 * COL_WIDTH + 2;
  // Wide enough that accumulator + combined beat can never wrap, so the
  // saturation decision is made on the exact sum.
  localparam int SUM_W  = ((ACC_WIDTH > COMB_W) ? ACC_WIDTH : COMB_W) + 2;

  state_e                 state_q, state_d;
  run_cfg_t               cfg_q, cfg_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   count_q, count_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   sat_q, sat_d;

  logic signed [COMB_W-1:0]      combined;
  logic signed [SUM_W-1:0]       acc_ext, comb_ext, sum_full;
  logic [SUM_W-ACC_WIDTH:0]      sum_top;
  logic [ACC_WIDTH-1:0]          sum_clamped;
  logic                          sum_ovf;

  // The merge always follows the latched configuration, never the live pins.
  psum_combine #(
    .COL_WIDTH (COL_WIDTH),
    .OUT_WIDTH (COMB_W)
  ) u_combine (
    .weight_width_i (cfg_q.ww),
    .sgn_i          (cfg_q.sgn),
    .psum_i         (psum_in),
    .combined_o     (combined)
  );

  // ---------------------------------------------------------------------------
  // Full-precision sum and clamp
  // ---------------------------------------------------------------------------
  // In unsigned runs the accumulator holds 0..2^W-1, so it must be
  // zero-extended; in signed runs it is a two's-complement value.
  assign acc_ext  = {{(SUM_W - ACC_WIDTH){cfg_q.sgn & acc_q[ACC_WIDTH-1]}}, acc_q};
  assign comb_ext = {{(SUM_W - COMB_W){combined[COMB_W-1]}}, combined};
  assign sum_full = acc_ext + comb_ext;

  // Bits from the result's sign position upward; for a representable signed
  // result these are all copies of one bit.
  assign sum_top  = sum_full[SUM_W-1:ACC_WIDTH-1];

  always_comb begin
    sum_clamped = sum_full[ACC_WIDTH-1:0];
    sum_ovf     = 1'b0;
    if (cfg_q.sgn) begin
      if (!((&sum_top) || (~|sum_top))) begin
        sum_ovf     = 1'b1;
        sum_clamped = sum_full[SUM_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else if (|sum_full[SUM_W-1:ACC_WIDTH]) begin
      // Negative sums clamp to zero, too-large sums to all ones.
      sum_ovf     = 1'b1;
      sum_clamped = sum_full[SUM_W-1] ? '0 : '1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned and infers a latch.
    state_d = state_q;
    cfg_d   = cfg_q;
    len_d   = len_q;
    count_d = count_q;
    acc_d   = acc_q;
    sat_d   = sat_q;

    unique case (state_q)
      IDLE: begin
        if (start && (acc_len != '0)) begin
          state_d   = ACCUM;
          cfg_d.ww  = weight_width;
          cfg_d.sgn = s_in | s_weight;
          len_d     = acc_len;
          count_d   = '0;
          acc_d     = '0;
          sat_d     = 1'b0;
        end
      end

      ACCUM: begin
        if (psum_valid) begin
          acc_d   = sum_clamped;
          sat_d   = sat_q | sum_ovf;
          count_d = count_q + LEN_WIDTH'(1);
          if (count_d == len_q) begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (acc_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      len_q   <= len_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign acc_valid = (state_q == HOLD);
  assign acc_out   = acc_q;
  assign sat       = sat_q;

endmodule : fusion_accumulator
